approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter W, default 8: operand width, even, 4..16.
REQ-002 Parameter L, default 4: number of low multiplier rows approximated; even, 0..W.
REQ-003 Parameter T, default W-1: truncation column; approximated-row bits below column T are dropped.
REQ-004 Parameter ACC_W, default 32: error accumulator width.
REQ-005 clk  input  1  rising-edge clock; one clock domain.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  operand beat valid.
REQ-008 in_ready  output  1  block accepts operand beat.
REQ-009 in_x, in_y  input  W each  unsigned operands; in_x is the multiplier (rows), in_y is the multiplicand.
REQ-010 in_mode  input  1  0 = exact, 1 = approximate; captured per beat.
REQ-011 out_valid  input-side handshake output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_z  output  2W  product.
REQ-014 out_err  output  2W  exact product minus out_z; 0 in exact mode.
REQ-015 clr_acc  input  1  synchronous clear of statistics.
REQ-016 err_acc  output  ACC_W  saturating sum of out_err over delivered results.
REQ-017 txn_cnt  output  16  saturating count of delivered approximate-mode results.

Function
REQ-018 Let PP[i] = in_y AND x[i], shifted left by i; the high part H = in_y * in_x[W-1:L] shifted left by L, exact.
REQ-019 For each pair k = 0..L/2-1, C[k] = PP[2k] OR PP[2k+1], with bits in columns below T forced to 0.
REQ-020 Approximate result = H + sum of C[k], computed to 2W bits without overflow; exact result = in_x * in_y.
REQ-021 out_z equals the approximate result when mode = 1 and the exact result when mode = 0; out_err = exact - out_z, which is never negative.
REQ-022 Two-stage pipeline: S1 registers H, the C terms, the exact product and the mode; S2 registers out_z and out_err. Latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid when out_ready is held at 1.
REQ-023 Throughput is one beat per cycle when out_ready = 1.
REQ-024 Each stage advances when it is empty or when its successor advances; in_ready = !S1_valid || S1 advances.
REQ-025 out_valid and out_z/out_err stay stable while out_valid && !out_ready; no beat is dropped or duplicated.
REQ-026 On each out_valid&&out_ready: err_acc += out_err, saturating at 2^ACC_W-1; in approximate mode, txn_cnt += 1, saturating at 65535.
REQ-027 clr_acc with a simultaneous delivery: err_acc loads that beat's out_err and txn_cnt loads the beat's mode bit. clr_acc alone loads 0 into both.
REQ-028 L = 0 degenerates to an exact multiplier; err_acc stays 0.

Reset
REQ-029 While rst_n = 0, all valid flags, out_z, out_err, err_acc and txn_cnt are 0. in_ready is 1 once rst_n deasserts.
REQ-030 Reset asserted mid-operation discards all in-flight beats; no out_valid appears until new input is accepted.

Structure
REQ-031 Package approx_mult_pkg holds the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1) and the parameter defaults.
REQ-032 Sub-module approx_pp_compress is purely combinational. It takes in_x, in_y, W, L and T and produces H plus the compressed C sum. It has no state.
REQ-033 All pipeline state, handshake logic and statistics live in approx_mult_pipe.

Verification (W=8, L=4, T=7)
REQ-034 x=255, y=255, mode=1 -> out_z=63504, out_err=1521, after 2 cycles; same operands with mode=0 -> out_z=65025, out_err=0.
REQ-035 x=3, y=200, mode=1 -> out_z=384, out_err=216; x=16, y=10, mode=1 -> out_z=160, out_err=0.
REQ-036 Back-to-back beats with out_ready=1 -> one result per cycle, in order. Hold out_ready=0 for 5 cycles -> in_ready drops after 2 beats are buffered, and outputs stay stable.
REQ-037 Deliver the three mode=1 beats of REQ-034 and REQ-035 -> err_acc=1737, txn_cnt=3. Then clr_acc together with the mode=1 255x255 delivery -> err_acc=1521, txn_cnt=1.
REQ-038 Assert rst_n=0 with 2 beats in flight -> out_valid=0, err_acc=0 and no stale output after release. A random 10k-beat run matches the reference model of REQ-018..REQ-021.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants for the approximate multiplier pipeline: mode encoding
// and parameter defaults.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int W_DEF     = 8;
  localparam int L_DEF     = 4;
  localparam int ACC_W_DEF = 32;
  localparam int TXN_W     = 16;

endpackage

// File: rtl/approx_pp_compress.sv
// Combinational partial-product generator: exact high rows plus OR-compressed,
// column-truncated low row pairs.
module approx_pp_compress
  import approx_mult_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int L = L_DEF,
  parameter int T = W - 1
) (
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic [2*W-1:0] h,
  output logic [2*W-1:0] c_sum
);

  localparam int PW = 2 * W;
  localparam logic [PW-1:0] T_MASK = ~((PW'(1) << T) - PW'(1));

  logic [PW-1:0] y_ext;
  logic [PW-1:0] pp_a;
  logic [PW-1:0] pp_b;
  logic [W-1:0]  x_sh;

  assign y_ext = PW'(in_y);
  assign h     = (y_ext * PW'(in_x >> L)) << L;

  // Each low row pair collapses to a single OR row; columns below T are dropped.
  always_comb begin
    c_sum = '0;
    pp_a  = '0;
    pp_b  = '0;
    x_sh  = '0;
    for (int k = 0; k < L / 2; k++) begin
      x_sh  = in_x >> (2 * k);
      pp_a  = x_sh[0] ? (y_ext << (2 * k)) : '0;
      pp_b  = x_sh[1] ? (y_ext << (2 * k + 1)) : '0;
      c_sum = c_sum + ((pp_a | pp_b) & T_MASK);
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready approximate multiplier with per-beat exact/approx mode
// and saturating error / transaction statistics.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int L     = L_DEF,
  parameter int T     = W - 1,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [2*W-1:0]   out_err,
  input  logic             clr_acc,
  output logic [ACC_W-1:0] err_acc,
  output logic [TXN_W-1:0] txn_cnt
);

  localparam int PW    = 2 * W;
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

  logic [PW-1:0] h_p0, c_p0, exact_p0;
  logic [PW-1:0] h_p1, c_p1, exact_p1;
  logic [PW-1:0] z_p1, err_p1;
  logic [PW-1:0] z_p2, err_p2;
  logic          mode_p1, vld_p1;
  logic          mode_p2, vld_p2;
  logic          s2_ready, accept, deliver;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({ACC_W{1'b1}})) return {ACC_W{1'b1}};
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [TXN_W-1:0] sat_inc(input logic [TXN_W-1:0] a);
    return (a == {TXN_W{1'b1}}) ? a : a + TXN_W'(1);
  endfunction

  approx_pp_compress #(.W(W), .L(L), .T(T)) u_pp (
    .in_x  (in_x),
    .in_y  (in_y),
    .h     (h_p0),
    .c_sum (c_p0)
  );

  assign exact_p0  = PW'(in_x) * PW'(in_y);
  assign s2_ready  = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s2_ready;
  assign accept    = in_valid && in_ready;
  assign deliver   = vld_p2 && out_ready;
  assign out_valid = vld_p2;
  assign out_z     = z_p2;
  assign out_err   = err_p2;

  // Stage 1: partial-product terms, exact product and mode.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_p1     <= h_p0;
      c_p1     <= c_p0;
      exact_p1 <= exact_p0;
      mode_p1  <= in_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  assign z_p1   = (mode_p1 == MODE_APPROX) ? (h_p1 + c_p1) : exact_p1;
  assign err_p1 = exact_p1 - z_p1;

  // Stage 2: final product and its error against the exact product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      mode_p2 <= MODE_EXACT;
      z_p2    <= '0;
      err_p2  <= '0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mode_p2 <= mode_p1;
        z_p2    <= z_p1;
        err_p2  <= err_p1;
      end
    end
  end

  // Statistics: a clear coinciding with a delivery restarts from that beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc <= '0;
      txn_cnt <= '0;
    end else if (clr_acc) begin
      err_acc <= deliver ? sat_acc('0, err_p2) : '0;
      txn_cnt <= (deliver && mode_p2 == MODE_APPROX) ? TXN_W'(1) : '0;
    end else if (deliver) begin
      err_acc <= sat_acc(err_acc, err_p2);
      if (mode_p2 == MODE_APPROX) txn_cnt <= sat_inc(txn_cnt);
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed and randomized checks of approx_mult_pipe at W=8, L=4, T=7.
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  localparam int W     = 8;
  localparam int L     = 4;
  localparam int T     = 7;
  localparam int ACC_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_z;
  logic [2*W-1:0]   out_err;
  logic             clr_acc;
  logic [ACC_W-1:0] err_acc;
  logic [TXN_W-1:0] txn_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(W), .L(L), .T(T), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_err   (out_err),
    .clr_acc   (clr_acc),
    .err_acc   (err_acc),
    .txn_cnt   (txn_cnt)
  );

  function automatic logic [15:0] model_z(input logic [7:0] x, input logic [7:0] y,
                                          input logic m);
    int unsigned hi, c, a, b, mask;
    if (!m) return 16'(32'(x) * 32'(y));
    hi   = (32'(y) * (32'(x) >> L)) << L;
    mask = ~((32'd1 << T) - 32'd1);
    c    = 0;
    for (int k = 0; k < L / 2; k++) begin
      a = (((32'(x) >> (2 * k)) & 32'd1) != 0) ? (32'(y) << (2 * k)) : 32'd0;
      b = (((32'(x) >> (2 * k + 1)) & 32'd1) != 0) ? (32'(y) << (2 * k + 1)) : 32'd0;
      c = c + ((a | b) & mask);
    end
    return 16'(hi + c);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_mode = 1'b0;
    out_ready = 1'b1; clr_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
    n_tests++; if (out_z !== 16'd0) begin n_fail++; $display("FAIL rst_out_z: got %0d expected 0", out_z); end
    n_tests++; if (out_err !== 16'd0) begin n_fail++; $display("FAIL rst_out_err: got %0d expected 0", out_err); end
    n_tests++; if (err_acc !== 32'd0) begin n_fail++; $display("FAIL rst_err_acc: got %0d expected 0", err_acc); end
    n_tests++; if (txn_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_txn_cnt: got %0d expected 0", txn_cnt); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0d expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int vx[7] = '{255, 255, 3, 16, 1, 12, 5};
    int vy[7] = '{255, 255, 200, 10, 255, 100, 7};
    int vm[7] = '{1, 0, 1, 1, 1, 1, 0};
    int ez[7] = '{63504, 65025, 384, 160, 128, 896, 35};
    int ee[7] = '{1521, 0, 216, 0, 127, 304, 0};
    for (int i = 0; i < 7; i++) begin
      in_x = 8'(vx[i]); in_y = 8'(vy[i]); in_mode = vm[i][0]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %0d expected 0", i, out_valid); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid: got %0d expected 1", i, out_valid); end
      n_tests++; if (out_z !== 16'(ez[i])) begin n_fail++; $display("FAIL vec%0d_z: got %0d expected %0d", i, out_z, ez[i]); end
      n_tests++; if (out_err !== 16'(ee[i])) begin n_fail++; $display("FAIL vec%0d_err: got %0d expected %0d", i, out_err, ee[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int vx[5] = '{2, 10, 255, 13, 255};
    int vy[5] = '{3, 20, 1, 11, 255};
    int vm[5] = '{0, 0, 0, 0, 1};
    int ez[5] = '{6, 200, 255, 143, 63504};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        in_x = 8'(vx[i]); in_y = 8'(vy[i]); in_mode = vm[i][0]; in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_in_ready: got %0d expected 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_z !== 16'(ez[i-1])) begin
          n_fail++; $display("FAIL b2b%0d_out: got valid=%0d z=%0d expected valid=1 z=%0d", i - 1, out_valid, out_z, ez[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %0d expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_x = 8'd2; in_y = 8'd3; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 8'd10; in_y = 8'd20;
    @(posedge clk); #1;
    in_x = 8'd13; in_y = 8'd11;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %0d expected 0", in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_z !== 16'd6 || out_err !== 16'd0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%0d z=%0d err=%0d in_ready=%0d expected 1 6 0 0", c, out_valid, out_z, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_release: got %0d expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (out_z !== 16'd200) begin n_fail++; $display("FAIL bp_second: got %0d expected 200", out_z); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_z !== 16'd143) begin n_fail++; $display("FAIL bp_third: got valid=%0d z=%0d expected 1 143", out_valid, out_z); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0d expected 0", out_valid); end
  endtask

  task automatic test_stats();
    int vx[3] = '{255, 3, 16};
    int vy[3] = '{255, 200, 10};
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    n_tests++; if (err_acc !== 32'd0 || txn_cnt !== 16'd0) begin n_fail++; $display("FAIL st_clear: got acc=%0d cnt=%0d expected 0 0", err_acc, txn_cnt); end
    for (int i = 0; i < 3; i++) begin
      in_x = 8'(vx[i]); in_y = 8'(vy[i]); in_mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (err_acc !== 32'd1737) begin n_fail++; $display("FAIL st_err_acc: got %0d expected 1737", err_acc); end
    n_tests++; if (txn_cnt !== 16'd3) begin n_fail++; $display("FAIL st_txn_cnt: got %0d expected 3", txn_cnt); end
    in_x = 8'd255; in_y = 8'd255; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL st_clr_beat_valid: got %0d expected 1", out_valid); end
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    n_tests++; if (err_acc !== 32'd1521 || txn_cnt !== 16'd1) begin n_fail++; $display("FAIL st_clr_deliver: got acc=%0d cnt=%0d expected 1521 1", err_acc, txn_cnt); end
    in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (err_acc !== 32'd1521 || txn_cnt !== 16'd1) begin n_fail++; $display("FAIL st_exact_beat: got acc=%0d cnt=%0d expected 1521 1", err_acc, txn_cnt); end
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    n_tests++; if (err_acc !== 32'd0 || txn_cnt !== 16'd0) begin n_fail++; $display("FAIL st_clr_alone: got acc=%0d cnt=%0d expected 0 0", err_acc, txn_cnt); end
  endtask

  task automatic test_reset_midflight();
    in_x = 8'd255; in_y = 8'd255; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_x = 8'd3; in_y = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || err_acc !== 32'd0) begin n_fail++; $display("FAIL mid_rst: got valid=%0d acc=%0d expected 0 0", out_valid, err_acc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d: got %0d expected 0", c, out_valid); end
    end
    in_x = 8'd16; in_y = 8'd10; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || out_z !== 16'd160) begin n_fail++; $display("FAIL mid_new_beat: got valid=%0d z=%0d expected 1 160", out_valid, out_z); end
    @(posedge clk); #1;
    n_tests++; if (err_acc !== 32'd0 || txn_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_stats: got acc=%0d cnt=%0d expected 0 1", err_acc, txn_cnt); end
  endtask

  task automatic test_random();
    logic [15:0] qz[$];
    logic [15:0] qe[$];
    logic [15:0] ez, ee;
    logic        acc, del;
    int          got = 0;
    int          cyc = 0;
    while (got < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = 8'($urandom);
      in_y      = 8'($urandom);
      in_mode   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        n_tests++;
        if (qz.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: got z=%0d expected no beat", out_z);
        end else begin
          ez = qz.pop_front();
          ee = qe.pop_front();
          got++;
          if (out_z !== ez || out_err !== ee) begin
            n_fail++; $display("FAIL rnd_beat%0d: got z=%0d err=%0d expected z=%0d err=%0d", got, out_z, out_err, ez, ee);
          end
        end
      end
      if (acc) begin
        ez = model_z(in_x, in_y, in_mode);
        qz.push_back(ez);
        qe.push_back(16'(32'(in_x) * 32'(in_y)) - ez);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (got < 10000) begin n_fail++; $display("FAIL rnd_timeout: got %0d beats expected 10000", got); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_stats();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
